// File: rtl/sdhci_pkg.sv
// Shared types for the SDHCI DAT transfer controller: FSM states, the
// register-update bundle driven into Block Count, and the block word-count helper.
package sdhci_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CARD = 3'd1,
        ST_RD_HOST = 3'd2,
        ST_WR_HOST = 3'd3,
        ST_WR_CARD = 3'd4,
        ST_STOP    = 3'd5
    } xfer_state_e;

    // Hardware update port of a software-writable register: d is loaded when de is high.
    typedef struct packed {
        logic [15:0] d;
        logic        de;
    } writable_reg_t;

    // Number of 32-bit words in a block, rounding a partial final word up.
    function automatic logic [10:0] block_words(input logic [11:0] size_bytes);
        return 11'(({1'b0, size_bytes} + 13'd3) >> 2);
    endfunction

endpackage

// File: rtl/sdhci_dat_xfer_ctrl.sv
// Block-level sequencer between the host Buffer Data Port and the DAT line engine:
// Present State flags, Block Count updates, Auto CMD12 request and buffer word address.
module sdhci_dat_xfer_ctrl
    import sdhci_pkg::*;
#(
    parameter int MaxBlkWords = 512,
    parameter int PtrW        = $clog2(MaxBlkWords)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            soft_rst_i,
    input  logic            start_i,
    input  logic            dir_read_i,
    input  logic            multi_block_i,
    input  logic            block_count_en_i,
    input  logic            auto_cmd12_en_i,
    input  logic [15:0]     block_count_i,
    input  logic [11:0]     block_size_i,
    input  logic            buf_rd_i,
    input  logic            buf_wr_i,
    output logic            dat_start_o,
    input  logic            dat_block_done_i,
    input  logic            dat_error_i,
    output logic            auto_cmd12_req_o,
    input  logic            auto_cmd12_ack_i,
    output logic [PtrW-1:0] word_ptr_o,
    output logic            buffer_read_enable_o,
    output logic            buffer_write_enable_o,
    output logic            read_transfer_active_o,
    output logic            write_transfer_active_o,
    output writable_reg_t   block_count_hw_o,
    output logic            busy_o
);

    xfer_state_e   r_state, w_state_nx;
    logic          r_dir, w_dir_nx, r_multi, w_multi_nx;
    logic          r_cnt_en, w_cnt_en_nx, r_auto12, w_auto12_nx;
    logic [15:0]   r_remaining, w_remaining_nx;
    logic [PtrW-1:0] r_ptr, w_ptr_nx, r_last_ptr, w_last_ptr_nx;
    logic          r_dat_start, w_dat_start_nx, r_cmd12, w_cmd12_nx;
    logic          r_rd_en, w_rd_en_nx, r_wr_en, w_wr_en_nx;
    logic          r_rd_act, w_rd_act_nx, r_wr_act, w_wr_act_nx;
    writable_reg_t r_bc_hw, w_bc_hw_nx;

    logic [10:0]     w_words;
    logic [PtrW-1:0] w_start_last_ptr;
    logic            w_start_ok, w_last, w_block_end, w_data_phase;

    assign w_words          = block_words(block_size_i);
    assign w_start_last_ptr = PtrW'(w_words - 11'd1);
    assign w_start_ok       = start_i && (block_size_i != 12'd0) &&
                              !(multi_block_i && block_count_en_i && (block_count_i == 16'd0));
    // An open-ended multi-block transfer (count disabled) never reaches a last block.
    assign w_last           = !r_multi || (r_cnt_en && (r_remaining == 16'd1));
    assign w_data_phase     = (r_state == ST_RD_CARD) || (r_state == ST_RD_HOST) ||
                              (r_state == ST_WR_HOST) || (r_state == ST_WR_CARD);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        w_state_nx     = r_state;
        w_dir_nx       = r_dir;
        w_multi_nx     = r_multi;
        w_cnt_en_nx    = r_cnt_en;
        w_auto12_nx    = r_auto12;
        w_remaining_nx = r_remaining;
        w_ptr_nx       = r_ptr;
        w_last_ptr_nx  = r_last_ptr;
        w_dat_start_nx = 1'b0;
        w_cmd12_nx     = 1'b0;
        w_rd_en_nx     = r_rd_en;
        w_wr_en_nx     = r_wr_en;
        w_rd_act_nx    = r_rd_act;
        w_wr_act_nx    = r_wr_act;
        w_bc_hw_nx     = '0;
        w_block_end    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_dir_nx       = dir_read_i;
                    w_multi_nx     = multi_block_i;
                    w_cnt_en_nx    = block_count_en_i;
                    w_auto12_nx    = auto_cmd12_en_i;
                    w_remaining_nx = block_count_i;
                    w_last_ptr_nx  = w_start_last_ptr;
                    w_ptr_nx       = '0;
                    if (dir_read_i) begin
                        w_state_nx     = ST_RD_CARD;
                        w_dat_start_nx = 1'b1;
                        w_rd_act_nx    = 1'b1;
                    end else begin
                        w_state_nx = ST_WR_HOST;
                        w_wr_en_nx = 1'b1;
                    end
                end
            end
            ST_RD_CARD: begin
                if (dat_block_done_i) begin
                    w_state_nx = ST_RD_HOST;
                    w_rd_en_nx = 1'b1;
                    w_ptr_nx   = '0;
                end
            end
            ST_RD_HOST: begin
                if (buf_rd_i) begin
                    if (r_ptr == r_last_ptr) begin
                        w_block_end = 1'b1;
                        w_rd_en_nx  = 1'b0;
                        w_ptr_nx    = '0;
                    end else begin
                        w_ptr_nx = r_ptr + PtrW'(1);
                    end
                end
            end
            ST_WR_HOST: begin
                if (buf_wr_i) begin
                    if (r_ptr == r_last_ptr) begin
                        w_state_nx     = ST_WR_CARD;
                        w_dat_start_nx = 1'b1;
                        w_wr_en_nx     = 1'b0;
                        w_wr_act_nx    = 1'b1;
                        w_ptr_nx       = '0;
                    end else begin
                        w_ptr_nx = r_ptr + PtrW'(1);
                    end
                end
            end
            ST_WR_CARD: begin
                if (dat_block_done_i) w_block_end = 1'b1;
            end
            ST_STOP: begin
                if (auto_cmd12_ack_i) begin
                    w_state_nx  = ST_IDLE;
                    w_rd_act_nx = 1'b0;
                    w_wr_act_nx = 1'b0;
                end else begin
                    w_cmd12_nx = 1'b1;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase

        if (w_block_end) begin
            if (r_multi && r_cnt_en) begin
                w_bc_hw_nx.de  = 1'b1;
                w_bc_hw_nx.d   = r_remaining - 16'd1;
                w_remaining_nx = r_remaining - 16'd1;
            end
            if (!w_last) begin
                if (r_dir) begin
                    w_state_nx     = ST_RD_CARD;
                    w_dat_start_nx = 1'b1;
                end else begin
                    w_state_nx = ST_WR_HOST;
                    w_wr_en_nx = 1'b1;
                end
            end else if (r_auto12) begin
                // Active flags stay up through STOP so Transfer Complete follows CMD12.
                w_state_nx = ST_STOP;
                w_cmd12_nx = 1'b1;
            end else begin
                w_state_nx  = ST_IDLE;
                w_rd_act_nx = 1'b0;
                w_wr_act_nx = 1'b0;
            end
        end

        // Soft reset and DAT errors override everything, including a same-cycle block done.
        if (soft_rst_i || (dat_error_i && w_data_phase)) begin
            w_state_nx     = ST_IDLE;
            w_ptr_nx       = '0;
            w_dat_start_nx = 1'b0;
            w_cmd12_nx     = 1'b0;
            w_rd_en_nx     = 1'b0;
            w_wr_en_nx     = 1'b0;
            w_rd_act_nx    = 1'b0;
            w_wr_act_nx    = 1'b0;
            w_bc_hw_nx     = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_dir       <= 1'b0;
            r_multi     <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_auto12    <= 1'b0;
            r_remaining <= '0;
            r_ptr       <= '0;
            r_last_ptr  <= '0;
            r_dat_start <= 1'b0;
            r_cmd12     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_wr_en     <= 1'b0;
            r_rd_act    <= 1'b0;
            r_wr_act    <= 1'b0;
            r_bc_hw     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_dir       <= w_dir_nx;
            r_multi     <= w_multi_nx;
            r_cnt_en    <= w_cnt_en_nx;
            r_auto12    <= w_auto12_nx;
            r_remaining <= w_remaining_nx;
            r_ptr       <= w_ptr_nx;
            r_last_ptr  <= w_last_ptr_nx;
            r_dat_start <= w_dat_start_nx;
            r_cmd12     <= w_cmd12_nx;
            r_rd_en     <= w_rd_en_nx;
            r_wr_en     <= w_wr_en_nx;
            r_rd_act    <= w_rd_act_nx;
            r_wr_act    <= w_wr_act_nx;
            r_bc_hw     <= w_bc_hw_nx;
        end
    end

    assign dat_start_o             = r_dat_start;
    assign auto_cmd12_req_o        = r_cmd12;
    assign word_ptr_o              = r_ptr;
    assign buffer_read_enable_o    = r_rd_en;
    assign buffer_write_enable_o   = r_wr_en;
    assign read_transfer_active_o  = r_rd_act;
    assign write_transfer_active_o = r_wr_act;
    assign block_count_hw_o        = r_bc_hw;
    assign busy_o                  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sdhci_dat_xfer_ctrl.sv
// Directed bench for sdhci_dat_xfer_ctrl: read/write paths, block counting,
// Auto CMD12, DAT error abort, rejected starts and soft reset.
module tb_sdhci_dat_xfer_ctrl;
    import sdhci_pkg::*;

    localparam int PtrW = 9;

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            soft_rst_i, start_i, dir_read_i, multi_block_i;
    logic            block_count_en_i, auto_cmd12_en_i;
    logic [15:0]     block_count_i;
    logic [11:0]     block_size_i;
    logic            buf_rd_i, buf_wr_i, dat_block_done_i, dat_error_i, auto_cmd12_ack_i;
    logic            dat_start_o, auto_cmd12_req_o;
    logic [PtrW-1:0] word_ptr_o;
    logic            buffer_read_enable_o, buffer_write_enable_o;
    logic            read_transfer_active_o, write_transfer_active_o, busy_o;
    writable_reg_t   block_count_hw_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    sdhci_dat_xfer_ctrl dut (
        .clk_i                   (clk_i),
        .rst_ni                  (rst_ni),
        .soft_rst_i              (soft_rst_i),
        .start_i                 (start_i),
        .dir_read_i              (dir_read_i),
        .multi_block_i           (multi_block_i),
        .block_count_en_i        (block_count_en_i),
        .auto_cmd12_en_i         (auto_cmd12_en_i),
        .block_count_i           (block_count_i),
        .block_size_i            (block_size_i),
        .buf_rd_i                (buf_rd_i),
        .buf_wr_i                (buf_wr_i),
        .dat_start_o             (dat_start_o),
        .dat_block_done_i        (dat_block_done_i),
        .dat_error_i             (dat_error_i),
        .auto_cmd12_req_o        (auto_cmd12_req_o),
        .auto_cmd12_ack_i        (auto_cmd12_ack_i),
        .word_ptr_o              (word_ptr_o),
        .buffer_read_enable_o    (buffer_read_enable_o),
        .buffer_write_enable_o   (buffer_write_enable_o),
        .read_transfer_active_o  (read_transfer_active_o),
        .write_transfer_active_o (write_transfer_active_o),
        .block_count_hw_o        (block_count_hw_o),
        .busy_o                  (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0; soft_rst_i = 1'b0; start_i = 1'b0; dir_read_i = 1'b0;
        multi_block_i = 1'b0; block_count_en_i = 1'b0; auto_cmd12_en_i = 1'b0;
        block_count_i = '0; block_size_i = '0; buf_rd_i = 1'b0; buf_wr_i = 1'b0;
        dat_block_done_i = 1'b0; dat_error_i = 1'b0; auto_cmd12_ack_i = 1'b0;
        tick(); tick();
        check("rst_busy", busy_o, 0);
        check("rst_ptr", word_ptr_o, 0);
        check("rst_de", block_count_hw_o.de, 0);
        check("rst_d", block_count_hw_o.d, 0);
        check("rst_flags", {dat_start_o, auto_cmd12_req_o, buffer_read_enable_o,
              buffer_write_enable_o, read_transfer_active_o, write_transfer_active_o}, 0);
        rst_ni = 1'b1;
        tick();

        // Strobes in IDLE are ignored.
        buf_rd_i = 1'b1; buf_wr_i = 1'b1; tick(); buf_rd_i = 1'b0; buf_wr_i = 1'b0;
        check("idle_strobe_ptr", word_ptr_o, 0);

        // Single read, size 8 -> 2 words.
        dir_read_i = 1'b1; block_size_i = 12'd8; start_i = 1'b1; tick(); start_i = 1'b0;
        check("r1_dat_start", dat_start_o, 1);
        check("r1_rd_active", read_transfer_active_o, 1);
        check("r1_busy", busy_o, 1);
        tick();
        check("r1_dat_start_pulse", dat_start_o, 0);
        dat_block_done_i = 1'b1; tick(); dat_block_done_i = 1'b0;
        check("r1_rd_en", buffer_read_enable_o, 1);
        check("r1_ptr0", word_ptr_o, 0);
        buf_rd_i = 1'b1; tick();
        check("r1_ptr1", word_ptr_o, 1);
        check("r1_rd_en_mid", buffer_read_enable_o, 1);
        tick(); buf_rd_i = 1'b0;
        check("r1_rd_en_end", buffer_read_enable_o, 0);
        check("r1_rd_active_end", read_transfer_active_o, 0);
        check("r1_busy_end", busy_o, 0);
        check("r1_no_de", block_count_hw_o.de, 0);

        // Single read, size 5 -> 2 words, pointer 0 then 1.
        block_size_i = 12'd5; start_i = 1'b1; tick(); start_i = 1'b0;
        dat_block_done_i = 1'b1; tick(); dat_block_done_i = 1'b0;
        check("r5_ptr0", word_ptr_o, 0);
        buf_rd_i = 1'b1; tick();
        check("r5_ptr1", word_ptr_o, 1);
        check("r5_busy_mid", busy_o, 1);
        tick(); buf_rd_i = 1'b0;
        check("r5_done", {busy_o, buffer_read_enable_o}, 0);

        // Multi write, count 3, size 512 (128 words), Auto CMD12.
        dir_read_i = 1'b0; multi_block_i = 1'b1; block_count_en_i = 1'b1;
        auto_cmd12_en_i = 1'b1; block_count_i = 16'd3; block_size_i = 12'd512;
        start_i = 1'b1; tick(); start_i = 1'b0;
        check("mw_wr_en", buffer_write_enable_o, 1);
        check("mw_wr_active_pre", write_transfer_active_o, 0);
        for (int b = 0; b < 3; b++) begin
            buf_wr_i = 1'b1;
            repeat (127) tick();
            check("mw_ptr127", word_ptr_o, 127);
            check("mw_wr_en_127", buffer_write_enable_o, 1);
            tick(); buf_wr_i = 1'b0;
            check("mw_dat_start", dat_start_o, 1);
            check("mw_wr_en_card", buffer_write_enable_o, 0);
            check("mw_wr_active", write_transfer_active_o, 1);
            check("mw_ptr_card", word_ptr_o, 0);
            buf_wr_i = 1'b1; tick(); buf_wr_i = 1'b0;
            check("mw_ignored_wr", word_ptr_o, 0);
            dat_block_done_i = 1'b1; tick(); dat_block_done_i = 1'b0;
            check("mw_de", block_count_hw_o.de, 1);
            check("mw_d", block_count_hw_o.d, 32'(2 - b));
            if (b < 2) begin
                check("mw_wr_en_next", buffer_write_enable_o, 1);
                check("mw_wr_active_gap", write_transfer_active_o, 1);
                check("mw_no_cmd12", auto_cmd12_req_o, 0);
            end else begin
                check("mw_cmd12_req", auto_cmd12_req_o, 1);
                check("mw_wr_active_stop", write_transfer_active_o, 1);
                check("mw_wr_en_stop", buffer_write_enable_o, 0);
            end
            tick();
            check("mw_de_pulse", block_count_hw_o.de, 0);
        end
        check("mw_cmd12_held", auto_cmd12_req_o, 1);
        auto_cmd12_ack_i = 1'b1; tick(); auto_cmd12_ack_i = 1'b0;
        check("mw_ack_wr_active", write_transfer_active_o, 0);
        check("mw_ack_cmd12", auto_cmd12_req_o, 0);
        check("mw_ack_busy", busy_o, 0);

        // Multi read, count 4, size 4 (1 word); error with done in the second RD_CARD.
        dir_read_i = 1'b1; block_count_i = 16'd4; block_size_i = 12'd4;
        start_i = 1'b1; tick(); start_i = 1'b0;
        dat_block_done_i = 1'b1; tick(); dat_block_done_i = 1'b0;
        check("mr_rd_en", buffer_read_enable_o, 1);
        buf_rd_i = 1'b1; tick(); buf_rd_i = 1'b0;
        check("mr_de", block_count_hw_o.de, 1);
        check("mr_d", block_count_hw_o.d, 3);
        check("mr_dat_start2", dat_start_o, 1);
        check("mr_rd_en_off", buffer_read_enable_o, 0);
        tick();
        dat_error_i = 1'b1; dat_block_done_i = 1'b1; tick();
        dat_error_i = 1'b0; dat_block_done_i = 1'b0;
        check("mr_err_busy", busy_o, 0);
        check("mr_err_flags", {buffer_read_enable_o, read_transfer_active_o,
              auto_cmd12_req_o, dat_start_o}, 0);
        check("mr_err_no_de", block_count_hw_o.de, 0);
        tick();
        check("mr_err_no_cmd12", auto_cmd12_req_o, 0);

        // Rejected starts: zero block count with counting, and zero block size.
        block_count_i = 16'd0; start_i = 1'b1; tick(); start_i = 1'b0;
        check("rej_cnt0_busy", busy_o, 0);
        check("rej_cnt0_start", dat_start_o, 0);
        multi_block_i = 1'b0; block_count_en_i = 1'b0; auto_cmd12_en_i = 1'b0;
        block_size_i = 12'd0; start_i = 1'b1; tick(); start_i = 1'b0;
        check("rej_size0_busy", busy_o, 0);

        // start_i during RD_HOST leaves the transfer untouched.
        block_size_i = 12'd8; start_i = 1'b1; tick(); start_i = 1'b0;
        dat_block_done_i = 1'b1; tick(); dat_block_done_i = 1'b0;
        dir_read_i = 1'b0; start_i = 1'b1; buf_wr_i = 1'b1; tick();
        start_i = 1'b0; buf_wr_i = 1'b0;
        check("rs_rd_en", buffer_read_enable_o, 1);
        check("rs_wr_en", buffer_write_enable_o, 0);
        check("rs_ptr", word_ptr_o, 0);
        check("rs_dat_start", dat_start_o, 0);
        buf_rd_i = 1'b1; tick(); tick(); buf_rd_i = 1'b0;
        check("rs_end_busy", busy_o, 0);

        // Soft reset in WR_HOST at pointer 10, then a fresh start.
        block_size_i = 12'd64; start_i = 1'b1; tick(); start_i = 1'b0;
        buf_wr_i = 1'b1; repeat (10) tick(); buf_wr_i = 1'b0;
        check("sr_ptr10", word_ptr_o, 10);
        soft_rst_i = 1'b1; tick(); soft_rst_i = 1'b0;
        check("sr_ptr", word_ptr_o, 0);
        check("sr_flags", {busy_o, buffer_write_enable_o, write_transfer_active_o,
              block_count_hw_o.de}, 0);
        dir_read_i = 1'b1; block_size_i = 12'd4; start_i = 1'b1; tick(); start_i = 1'b0;
        check("sr_restart", {dat_start_o, read_transfer_active_o, busy_o}, 3'b111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
